// File: rtl/bidir_line_pkg.sv
// Shared types and defaults for the half-duplex line controller.
package bidir_line_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_TURN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_TURN,
    ST_TX_SHIFT,
    ST_TX_REL,
    ST_RX_SHIFT
  } line_state_e;

endpackage

// File: rtl/bidir_bit_counter.sv
// Loadable down-counter with terminal-count flag, shared by the turn and shift phases.
module bidir_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/bidir_line_ctrl.sv
// Half-duplex serial controller: shifts words onto / off one shared line and
// drives the buffer direction enable with idle turnaround gaps around each burst.
module bidir_line_ctrl
  import bidir_line_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             rx_req,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             pad_out,
  output logic             pad_oe,
  input  logic             pad_in,
  output logic             busy
);

  localparam int CNT_MAX = (WIDTH > TURN_CYCLES) ? WIDTH : TURN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SHIFT_LD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] TURN_LD  = CW'(TURN_CYCLES - 1);

  line_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             pad_oe_q, pad_oe_d;
  logic             pad_out_q, pad_out_d;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             cnt_tc;

  bidir_bit_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tc_o       (cnt_tc)
  );

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is only offered in IDLE with no pending receive request.
  assign tx_ready = (state_q == ST_IDLE) && !rx_req;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    pad_oe_d   = 1'b0;
    pad_out_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_req) begin
          state_d = ST_RX_SHIFT;
        end else if (tx_valid) begin
          shreg_d = tx_data;
          state_d = ST_TX_TURN;
        end
      end
      ST_TX_TURN:  if (cnt_tc) state_d = ST_TX_SHIFT;
      ST_TX_SHIFT: if (cnt_tc) state_d = ST_TX_REL;
      ST_TX_REL:   if (cnt_tc) state_d = ST_IDLE;
      ST_RX_SHIFT: begin
        shreg_d = {pad_in, shreg_q[WIDTH-1:1]};
        if (cnt_tc) begin
          rx_data_d  = shreg_d;
          rx_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line outputs are computed from the state being entered so they leave a flop.
    if (state_d == ST_TX_SHIFT) begin
      pad_oe_d  = 1'b1;
      pad_out_d = shreg_q[0];
      shreg_d   = {1'b0, shreg_q[WIDTH-1:1]};
    end

    cnt_load = (state_d != state_q);
    if (state_d == ST_TX_SHIFT || state_d == ST_RX_SHIFT) begin
      cnt_load_val = SHIFT_LD;
    end else if (state_d == ST_IDLE) begin
      cnt_load_val = '0;
    end else begin
      cnt_load_val = TURN_LD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      pad_oe_q   <= 1'b0;
      pad_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      pad_oe_q   <= pad_oe_d;
      pad_out_q  <= pad_out_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign pad_oe   = pad_oe_q;
  assign pad_out  = pad_out_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bidir_line_ctrl.sv
// Two controllers on one shared line plus a bench-driven peer; waveforms are
// checked against expectations built from the timing rules of each transfer.
module tb_bidir_line_ctrl;
  import bidir_line_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int T = DEF_TURN_CYCLES;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
  logic a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
  logic a_rx_req, b_rx_req, a_rx_valid, b_rx_valid;
  logic a_pad_out, b_pad_out, a_pad_oe, b_pad_oe, a_busy, b_busy;
  logic tb_pad;
  logic line;

  // Shared line: whichever controller drives wins, otherwise the bench peer.
  assign line = a_pad_oe ? a_pad_out : (b_pad_oe ? b_pad_out : tb_pad);

  bidir_line_ctrl #(.WIDTH(W), .TURN_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_req(a_rx_req), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .pad_out(a_pad_out), .pad_oe(a_pad_oe), .pad_in(line), .busy(a_busy)
  );

  bidir_line_ctrl #(.WIDTH(W), .TURN_CYCLES(T)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_req(b_rx_req), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .pad_out(b_pad_out), .pad_oe(b_pad_oe), .pad_in(line), .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail = 0;
  int overlap_cnt = 0;
  bit lb_mode = 1'b0;
  logic [W-1:0] last_rx;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the receiving controller B, plus a contention monitor.
  always @(negedge clk) begin
    if (a_pad_oe && b_pad_oe) overlap_cnt++;
    if (b_rx_valid) begin
      if (exp_q.size() == 0) check("b_rx_extra", 32'd1, 32'd0);
      else check("b_rx_data", 32'(b_rx_data), 32'(exp_q.pop_front()));
    end
  end

  // Expected {pad_oe, pad_out, busy, tx_ready} in the i-th cycle after a handshake.
  function automatic logic [3:0] tx_model(input int i, input logic [W-1:0] d);
    logic oe, out;
    oe  = (i >= T) && (i < T + W);
    out = 1'b0;
    if (oe) out = d[i-T];
    return {oe, out, 2'b10};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", {a_pad_oe, a_pad_out, a_busy, a_tx_ready, a_rx_valid, a_rx_data},
            {5'b00010, last_rx});
      tb_pad = 1'($urandom_range(0, 1));
    end
  endtask

  // Caller has set inputs so the handshake happens at the next rising edge.
  task automatic tx_expect(input logic [W-1:0] d, input bit hold, input logic [W-1:0] nd);
    for (int i = 0; i < 2*T + W; i++) begin
      @(negedge clk);
      check("tx_line", {a_pad_oe, a_pad_out, a_busy, a_tx_ready}, tx_model(i, d));
      if (i == 0) begin
        a_tx_valid = hold;
        a_tx_data  = nd;
      end
      if (lb_mode) b_rx_req = (i == T - 1);
    end
    @(negedge clk);
    check("tx_ready_back", {a_pad_oe, a_pad_out, a_busy, a_tx_ready}, 4'b0001);
  endtask

  // Caller has raised a_rx_req so the receive starts at the next rising edge.
  task automatic rx_expect(input logic [W-1:0] d, input bit hold);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("rx_shift", {a_pad_oe, a_busy, a_rx_valid, a_tx_ready, a_rx_data},
            {4'b0100, last_rx});
      if (i == 0) a_rx_req = hold;
      tb_pad = d[i];
    end
    @(negedge clk);
    last_rx = d;
    check("rx_done", {a_pad_oe, a_busy, a_rx_valid, a_tx_ready, a_rx_data},
          {3'b001, !hold, d});
    tb_pad = 1'($urandom_range(0, 1));
  endtask

  task automatic do_tx(input logic [W-1:0] d);
    a_tx_valid = 1'b1;
    a_tx_data  = d;
    tx_expect(d, 1'b0, '0);
  endtask

  task automatic do_rx(input logic [W-1:0] d);
    a_rx_req = 1'b1;
    rx_expect(d, 1'b0);
  endtask

  task automatic do_both(input logic [W-1:0] td, input logic [W-1:0] rd);
    a_rx_req   = 1'b1;
    a_tx_valid = 1'b1;
    a_tx_data  = td;
    rx_expect(rd, 1'b0);
    tx_expect(td, 1'b0, '0);
  endtask

  task automatic do_loopback(input logic [W-1:0] d);
    lb_mode = 1'b1;
    exp_q.push_back(d);
    do_tx(d);
    lb_mode  = 1'b0;
    b_rx_req = 1'b0;
    check("lb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1 check("rst_async", {a_pad_oe, a_pad_out, a_busy, a_rx_valid, a_tx_ready, a_rx_data},
             {5'b00001, {W{1'b0}}});
    @(negedge clk);
    rst_n   = 1'b1;
    last_rx = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    a_tx_data = '0; a_tx_valid = 1'b0; a_rx_req = 1'b0;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_req = 1'b0;
    tb_pad = 1'b0;
    last_rx = '0;
    #1 rst_n = 1'b0;
    #1 check("reset", {a_pad_oe, a_pad_out, a_busy, a_rx_valid, a_tx_ready, a_rx_data},
             {5'b00001, {W{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    do_tx(8'hA5);
    do_rx(8'h3C);
    idle_cycles(2);
    do_both(8'h5A, 8'hC3);

    // Back-to-back transmits with tx_valid held between them.
    a_tx_valid = 1'b1;
    a_tx_data  = 8'h01;
    tx_expect(8'h01, 1'b1, 8'hFF);
    tx_expect(8'hFF, 1'b0, '0);

    // Back-to-back receives with rx_req held.
    a_rx_req = 1'b1;
    rx_expect(8'h81, 1'b1);
    rx_expect(8'h7E, 1'b0);

    do_loopback(8'h96);
    idle_cycles(1);

    // Reset in the middle of a transmit burst.
    a_tx_valid = 1'b1;
    a_tx_data  = 8'hFF;
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (T + 2) @(negedge clk);
    check("rst_pre_oe", {a_pad_oe, a_busy}, 2'b11);
    reset_pulse();
    idle_cycles(3);

    // Reset in the middle of a receive: no pulse, data discarded.
    a_rx_req = 1'b1;
    @(negedge clk);
    a_rx_req = 1'b0;
    tb_pad   = 1'b1;
    repeat (3) @(negedge clk);
    reset_pulse();
    idle_cycles(W + 2);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: do_tx(W'($urandom));
        1: do_rx(W'($urandom));
        2: begin
          a_rx_req = 1'b1;
          rx_expect(W'($urandom), 1'b1);
          rx_expect(W'($urandom), 1'b0);
        end
        3: do_both(W'($urandom), W'($urandom));
        default: do_loopback(W'($urandom));
      endcase
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(2);
    check("no_contention", 32'(overlap_cnt), 32'd0);
    check("b_pending", 32'(exp_q.size()), 32'd0);
    check("b_idle_end", {b_busy, b_tx_ready, b_pad_oe}, 3'b010);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
